// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: constants shared by the UART transmitter and receiver. Rev 1.0
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic parity_out(input logic acc, input int mode);
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// uart_tx_if: byte-request / serial-line bundle between a UART transmitter and its user. Rev 1.0
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx;

  modport master (output tx_start, din, input tx_busy, tx_done_tick, tx);
  modport slave  (input tx_start, din, output tx_busy, tx_done_tick, tx);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// uart_tx: UART serial transmitter, LSB-first start/data/parity/stop framing on a 16x s_tick.
// Rev 1.0
module uart_tx
  import uart_pkg::*;
#(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PAR_NONE
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     s_tick,
  uart_tx_if.slave bus
);

  localparam int S_W = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam logic [S_W-1:0] S_LAST_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_LAST_STOP = S_W'(SB_TICK - 1);
  localparam logic [2:0]     N_LAST      = 3'(D_BIT - 1);

  logic [2:0]     state_q, state_next;
  logic [S_W-1:0] s_q, s_next;
  logic [2:0]     n_q, n_next;
  logic [7:0]     shreg_q, shreg_next;
  logic           par_q, par_next;
  logic           tx_q, tx_next;
  logic           busy_q, busy_next;
  logic           done_q, done_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      s_q     <= s_next;
      n_q     <= n_next;
      shreg_q <= shreg_next;
      par_q   <= par_next;
      tx_q    <= tx_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
    end
  end

  // tx is computed one edge ahead so the line only ever changes from a flop.
  always_comb begin
    state_next = state_q;
    s_next     = s_q;
    n_next     = n_q;
    shreg_next = shreg_q;
    par_next   = par_q;
    tx_next    = tx_q;
    busy_next  = busy_q;
    done_next  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (bus.tx_start) begin
          shreg_next = bus.din;
          par_next   = 1'b0;
          s_next     = '0;
          n_next     = '0;
          state_next = ST_START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_LAST_BIT) begin
            s_next     = '0;
            n_next     = '0;
            state_next = ST_DATA;
            tx_next    = shreg_q[0];
          end else begin
            s_next = s_q + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST_BIT) begin
            s_next     = '0;
            par_next   = par_q ^ shreg_q[0];
            shreg_next = shreg_q >> 1;
            if (n_q == N_LAST) begin
              if (PARITY != PAR_NONE) begin
                state_next = ST_PARITY;
                tx_next    = parity_out(par_q ^ shreg_q[0], PARITY);
              end else begin
                state_next = ST_STOP;
                tx_next    = 1'b1;
              end
            end else begin
              n_next  = n_q + 3'd1;
              tx_next = shreg_q[1];
            end
          end else begin
            s_next = s_q + S_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST_BIT) begin
            s_next     = '0;
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            s_next = s_q + S_W'(1);
          end
        end
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (s_q == S_LAST_STOP) begin
            s_next     = '0;
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            s_next = s_q + S_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// tb_uart_tx: self-checking bench for uart_tx with no, even and odd parity instances.
module tb_uart_tx;
  import uart_pkg::*;

  typedef struct {
    int         inst;
    logic [7:0] din;
    logic       par;
  } vec_t;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic s_tick = 1'b0;
  int   tick_div = 1;
  int   tick_cnt = 0;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       smp_tx   [0:2047];
  logic       smp_busy [0:2047];
  logic       smp_done [0:2047];

  int         chain_pend = 0;
  logic [7:0] chain_din  = 8'h00;
  int         chain_at   = -1;
  int         poke_at    = -1;
  logic [7:0] poke_din   = 8'h00;

  vec_t vecs [6];

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();

  uart_tx #(.D_BIT(8), .SB_TICK(16), .PARITY(PAR_NONE)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .bus(if0));
  uart_tx #(.D_BIT(8), .SB_TICK(16), .PARITY(PAR_EVEN)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .bus(if1));
  uart_tx #(.D_BIT(8), .SB_TICK(16), .PARITY(PAR_ODD)) dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .bus(if2));

  logic [2:0] txv, busyv, donev;
  assign txv   = {if2.tx, if1.tx, if0.tx};
  assign busyv = {if2.tx_busy, if1.tx_busy, if0.tx_busy};
  assign donev = {if2.tx_done_tick, if1.tx_done_tick, if0.tx_done_tick};

  always #5 clk = ~clk;

  // Tick changes shortly after posedge, so it is stable when the bench looks at negedge.
  always @(posedge clk) begin
    #2;
    if (tick_div <= 1) begin
      s_tick = 1'b1;
    end else begin
      s_tick   = (tick_cnt == 0);
      tick_cnt = (tick_cnt + 1) % tick_div;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic clear_start();
    if0.tx_start = 1'b0;
    if1.tx_start = 1'b0;
    if2.tx_start = 1'b0;
  endtask

  task automatic set_start(input int inst, input logic [7:0] d);
    case (inst)
      0:       begin if0.tx_start = 1'b1; if0.din = d; end
      1:       begin if1.tx_start = 1'b1; if1.din = d; end
      default: begin if2.tx_start = 1'b1; if2.din = d; end
    endcase
  endtask

  task automatic send(input int inst, input logic [7:0] d);
    set_start(inst, d);
    exp_q.push_back(d);
  endtask

  // Sample j holds the DUT outputs during the clock after edge j of the frame.
  task automatic record(input int inst, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      clear_start();
      smp_tx[j]   = txv[inst];
      smp_busy[j] = busyv[inst];
      smp_done[j] = donev[inst];
      if (chain_pend != 0 && smp_done[j] === 1'b1) begin
        send(inst, chain_din);
        chain_pend = 0;
        chain_at   = j;
      end
      if (j == poke_at) set_start(inst, poke_din);
    end
  endtask

  task automatic check_frame(input string tag, input int inst, input int base, input int spc,
                             input logic [7:0] d, input logic par_bit);
    logic [10:0] fr;
    logic [7:0]  rx_byte;
    int          ns;
    int          end_i;
    int          bc;
    int          dc;
    int          badk;
    fr    = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1 + i] = d[i];
    ns = (inst != 0) ? 11 : 10;
    if (inst != 0) fr[9] = par_bit;
    for (int s = 0; s < ns; s++) begin
      badk = 0;
      for (int k = spc - 1; k >= 0; k--)
        if (smp_tx[base + s * spc + k] !== fr[s]) badk = k;
      chk($sformatf("%s slot%0d tx", tag, s), {31'd0, smp_tx[base + s * spc + badk]}, {31'd0, fr[s]});
    end
    for (int i = 0; i < 8; i++) rx_byte[i] = smp_tx[base + (1 + i) * spc + spc / 2];
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s rx byte: got %0h, required nothing pending", tag, rx_byte);
    end else begin
      chk($sformatf("%s rx byte", tag), {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
    end
    end_i = base + ns * spc;
    bc = 0;
    dc = 0;
    for (int j = base; j <= end_i; j++) begin
      bc += (smp_busy[j] === 1'b1) ? 1 : 0;
      dc += (smp_done[j] === 1'b1) ? 1 : 0;
    end
    chk($sformatf("%s busy clks", tag), bc, ns * spc);
    chk($sformatf("%s done count", tag), dc, 1);
    chk($sformatf("%s done at end", tag), {31'd0, smp_done[end_i]}, 32'd1);
  endtask

  initial begin
    int cnt;
    clear_start();
    if0.din = 8'h00;
    if1.din = 8'h00;
    if2.din = 8'h00;

    vecs[0] = '{0, 8'hA5, 1'b0};
    vecs[1] = '{1, 8'hA5, 1'b0};
    vecs[2] = '{1, 8'h07, 1'b1};
    vecs[3] = '{2, 8'hA5, 1'b1};
    vecs[4] = '{2, 8'h07, 1'b0};
    vecs[5] = '{0, 8'h3C, 1'b0};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset inst0", {29'd0, txv[0], busyv[0], donev[0]}, 32'h4);
    chk("reset inst1", {29'd0, txv[1], busyv[1], donev[1]}, 32'h4);
    chk("reset inst2", {29'd0, txv[2], busyv[2], donev[2]}, 32'h4);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].inst, vecs[i].din);
      record(vecs[i].inst, ((vecs[i].inst != 0) ? 11 : 10) * 16 + 1);
      check_frame($sformatf("vec%0d", i), vecs[i].inst, 0, 16, vecs[i].din, vecs[i].par);
      repeat (4) @(negedge clk);
    end

    // Back-to-back: second request lands in the done cycle.
    chain_din  = 8'h3C;
    chain_pend = 1;
    chain_at   = -1;
    send(0, 8'hA5);
    record(0, 322);
    chain_pend = 0;
    check_frame("b2b first", 0, 0, 16, 8'hA5, 1'b0);
    chk("b2b chain cycle", chain_at, 160);
    check_frame("b2b second", 0, 161, 16, 8'h3C, 1'b0);
    repeat (4) @(negedge clk);

    // Request while busy must be dropped.
    poke_at  = 40;
    poke_din = 8'hFF;
    send(0, 8'h00);
    record(0, 361);
    poke_at = -1;
    check_frame("ignored", 0, 0, 16, 8'h00, 1'b0);
    cnt = 0;
    for (int j = 161; j <= 360; j++) cnt += (smp_tx[j] === 1'b1) ? 1 : 0;
    chk("ignored idle line", cnt, 200);
    cnt = 0;
    for (int j = 0; j <= 360; j++) cnt += (smp_done[j] === 1'b1) ? 1 : 0;
    chk("ignored total done", cnt, 1);
    repeat (4) @(negedge clk);

    // Sparse ticks: one every 7 clks, start aligned to a tick.
    tick_div = 7;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10 && s_tick !== 1'b1; k++) @(negedge clk);
    send(0, 8'h81);
    record(0, 10 * 112 + 1);
    check_frame("sparse", 0, 0, 112, 8'h81, 1'b0);
    tick_div = 1;
    repeat (4) @(negedge clk);

    // Asynchronous reset during data bit 3.
    send(0, 8'h00);
    record(0, 70);
    chk("pre-reset tx", {31'd0, txv[0]}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async reset outs", {29'd0, txv[0], busyv[0], donev[0]}, 32'h4);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(0, 8'h55);
    record(0, 161);
    check_frame("post-reset", 0, 0, 16, 8'h55, 1'b0);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter, the transmit-side counterpart of the oversampling UART receiver.
- Takes a parallel byte on a one-cycle start strobe and shifts it out LSB-first on tx: start bit, D_BIT data bits, optional parity bit, then stop bit(s).
- Bit timing comes from the shared baud-rate generator's s_tick, 16 ticks per bit, so transmitter and receiver share one tick source.

Parameters:
- D_BIT, 8: number of data bits, legal range 5..8; din bits above D_BIT-1 are ignored.
- SB_TICK, 16: s_ticks in the stop period; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock; all flops rise on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- s_tick  in  1  one-clk-wide baud tick at 16x bit rate.
- tx_start  in  1  one-clk request to send din; sampled only in idle.
- din  in  8  byte to transmit; captured on accepted tx_start.
- tx_busy  out  1  high from the cycle after acceptance through the end of the stop period.
- tx_done_tick  out  1  one-clk pulse at frame completion.
- tx  out  1  serial line, idle high.

Behaviour:
- All outputs are registered; tx must not glitch.
- Reset (reset=0, async):
  - state=idle, tx=1, tx_busy=0, tx_done_tick=0, tick/bit counters=0, shift register=0.
  - Reset mid-frame aborts immediately: tx returns high asynchronously.
- States: idle, start, data, parity, stop.
- idle:
  - tx=1.
  - On tx_start=1, at the next edge: shift reg<=din, parity accumulator<=0, s counter<=0, state<=start, tx<=0, tx_busy<=1.
- start:
  - tx=0. Count s_tick.
  - On the 16th tick (s==15 and s_tick): s<=0, n<=0, state<=data, tx<=shift[0].
- data:
  - tx=shift[0]. On the 16th tick: parity^=shift[0], shift>>=1, s<=0.
  - If n==D_BIT-1: go to parity (PARITY!=0) or stop (PARITY==0). Otherwise n<=n+1.
  - tx is updated on the same edge to the next bit value.
- parity:
  - tx = accumulated XOR for even, inverted XOR for odd. Held 16 ticks, then state<=stop, tx<=1.
- stop:
  - tx=1. On s==SB_TICK-1 and s_tick: state<=idle, tx_busy<=0, tx_done_tick<=1 for exactly one cycle.
- Back-to-back frames:
  - tx_start is accepted in the same cycle tx_done_tick is high, because the state is already idle.
  - The next start bit follows the stop period with zero extra ticks.
- Ignored inputs:
  - tx_start while busy is ignored: no queuing, no corruption of the frame in flight.
  - din changes after acceptance have no effect.
- Ticks only advance bit timing; clocks without s_tick hold all state.
- Latency: tx_start edge to tx falling is 1 clk. Frame length is 16*(1+D_BIT+(PARITY?1:0)) + SB_TICK ticks.
- Counter widths:
  - s is wide enough for SB_TICK-1 (5 bits for SB_TICK up to 32).
  - n is 3 bits.
  - No counter wraps in a legal configuration.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams: idle/start/data/parity/stop, shared with the receiver where overlapping;
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - OVERSAMPLE=16.
- Single flat module; no sub-module needed. Parity is a one-bit XOR accumulator inside the FSMD.
- Two-block style: a register block plus a combinational next-state block.

Test Plan:
- D_BIT=8, PARITY=0, s_tick every clk, din=8'hA5, tx_start pulse:
  - tx reads 0,1,0,1,0,0,1,0,1,1, each for 16 clks (160 clks total);
  - tx_done_tick is one pulse at clk 161; tx_busy is high for exactly 160 clks.
- PARITY=1, din=8'hA5 (four ones):
  - parity slot = 0.
  - Repeat with din=8'h07: parity slot = 1.
  - PARITY=2 with 8'hA5: parity slot = 1.
- Back-to-back: tx_start asserted in the tx_done_tick cycle with din=8'h3C:
  - the second start bit begins the next clk with no idle gap;
  - a loopback uart_rx receives 8'hA5 then 8'h3C.
- Ignored input: tx_start with din=8'hFF asserted mid-data of an 8'h00 frame:
  - the frame stays all-zero data;
  - no extra frame follows; only one tx_done_tick.
- Sparse ticks: s_tick every 7 clks, din=8'h81:
  - each bit lasts 112 clks; tx stays constant between ticks.
- Reset: drive reset=0 during data bit 3:
  - tx=1, tx_busy=0, tx_done_tick=0 immediately, without waiting for a clk edge;
  - after release, a new tx_start with 8'h55 produces a clean frame.
